// File: rtl/lcd_cmd_sched.sv
// Host-to-LCD command scheduler: small FIFO feeding the controller one command
// at a time over its cmd/cmd_valid/busy handshake, terminating on WRITE.
module lcd_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int ACK_WIN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          lcd_busy,
  input  logic          lcd_done,
  output logic [2:0]    cmd,
  output logic          cmd_valid,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    issued_cnt,
  output logic          sched_done
);

  localparam int CW = $clog2(ACK_WIN + 1);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_REL,
    FLUSH,
    FIN
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      mem_q [DEPTH];
  logic [2:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            write_seen_q, write_seen_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      issued_q, issued_d;
  logic            done_q, done_d;
  logic [CW-1:0]   ack_q, ack_d;
  logic            push;
  logic            pop;

  assign host_ready = (count_q < (AW+1)'(DEPTH)) && !write_seen_q && (state_q != BOOT);
  assign push       = host_valid && host_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0) && !lcd_busy;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    write_seen_d = write_seen_q;
    if (push) begin
      mem_d[wr_ptr_q] = host_cmd;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (host_cmd == 3'd0) write_seen_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // cmd_valid is registered at the pop so it is high for exactly the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    issued_d    = issued_q;
    done_d      = done_q;
    ack_d       = ack_q;
    case (state_q)
      BOOT: begin
        if (!lcd_busy) state_d = IDLE;
      end
      IDLE: begin
        if (pop) begin
          cmd_d       = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          issued_d    = issued_q + 8'd1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        ack_d   = '0;
        state_d = (cmd_q == 3'd0) ? FLUSH : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (lcd_busy) begin
          state_d = WAIT_REL;
        end else if (ack_q == CW'(ACK_WIN - 1)) begin
          state_d = IDLE;
        end else begin
          ack_d = ack_q + CW'(1);
        end
      end
      WAIT_REL: begin
        if (!lcd_busy) state_d = IDLE;
      end
      FLUSH: begin
        if (lcd_done) begin
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_seen_q <= 1'b0;
      cmd_q        <= 3'd0;
      cmd_valid_q  <= 1'b0;
      issued_q     <= 8'd0;
      done_q       <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      write_seen_q <= write_seen_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      issued_q     <= issued_d;
      done_q       <= done_d;
      ack_q        <= ack_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign fifo_count = count_q;
  assign issued_cnt = issued_q;
  assign sched_done = done_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: transaction-level reference model fed by
// the same inputs, compared against every DUT output on each falling clock edge.
module tb_lcd_cmd_sched;

  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int ACK_WIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  host_cmd;
  logic        host_valid;
  logic        host_ready;
  logic        lcd_busy;
  logic        lcd_done;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [AW:0] fifo_count;
  logic [7:0]  issued_cnt;
  logic        sched_done;

  int total = 0;
  int bad   = 0;
  int ctl_mode = 1;

  lcd_cmd_sched #(.DEPTH(DEPTH), .AW(AW), .ACK_WIN(ACK_WIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .lcd_busy   (lcd_busy),
    .lcd_done   (lcd_done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .fifo_count (fifo_count),
    .issued_cnt (issued_cnt),
    .sched_done (sched_done)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted commands plus the one outstanding issue,
  // tracked by edges elapsed since it was popped.
  int m_q[$];
  bit m_booted, m_wseen, m_out, m_busy_seen, m_term, m_done, m_cv;
  int m_age, m_cmd, m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_booted    <= 1'b0;
      m_wseen     <= 1'b0;
      m_out       <= 1'b0;
      m_busy_seen <= 1'b0;
      m_term      <= 1'b0;
      m_done      <= 1'b0;
      m_cv        <= 1'b0;
      m_age       <= 0;
      m_cmd       <= 0;
      m_cnt       <= 0;
    end else begin
      bit accept;
      bit issue;
      int head;
      int age;
      accept = host_valid && m_booted && !m_wseen && (m_q.size() < DEPTH);
      issue  = m_booted && !m_out && (m_q.size() > 0) && !lcd_busy;
      age    = (m_age < 1000) ? m_age + 1 : m_age;
      head   = 0;
      if (issue) head = m_q.pop_front();
      if (accept) begin
        m_q.push_back(int'(host_cmd));
        if (host_cmd == 3'd0) m_wseen <= 1'b1;
      end
      if (!m_booted && !lcd_busy) m_booted <= 1'b1;
      m_cv <= issue;
      if (issue) begin
        m_cmd       <= head;
        m_cnt       <= (m_cnt + 1) % 256;
        m_out       <= 1'b1;
        m_term      <= (head == 0);
        m_age       <= 0;
        m_busy_seen <= 1'b0;
      end else if (m_out) begin
        m_age <= age;
        if (m_term) begin
          if (age >= 2 && lcd_done) m_done <= 1'b1;
        end else if (m_busy_seen) begin
          if (!lcd_busy) m_out <= 1'b0;
        end else if (age >= 2 && lcd_busy) begin
          m_busy_seen <= 1'b1;
        end else if (age >= 1 + ACK_WIN) begin
          m_out <= 1'b0;
        end
      end
    end
  end

  // Controller emulation: 0 idle, 1 held busy, 2 random busy, 3 busy pulse after each issue.
  initial begin
    lcd_busy = 1'b1;
    forever begin
      @(posedge clk);
      #4;
      case (ctl_mode)
        0: lcd_busy = 1'b0;
        1: lcd_busy = 1'b1;
        2: lcd_busy = ($urandom_range(0, 3) == 0);
        default: begin
          lcd_busy = 1'b0;
          if (cmd_valid) begin
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #4; end
            lcd_busy = 1'b1;
            repeat ($urandom_range(1, 4)) begin @(posedge clk); #4; end
            lcd_busy = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Offers one command until accepted or tries run out; want says whether acceptance is expected.
  task automatic applyStimulus(input logic [2:0] c, input int tries, input bit want);
    bit acc = 1'b0;
    host_valid = 1'b1;
    host_cmd   = c;
    for (int i = 0; i < tries && !acc; i++) begin
      @(negedge clk);
      acc = host_ready;
      @(posedge clk);
      #2;
    end
    host_valid = 1'b0;
    checkOutput("accept", 32'(acc), int'(want));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulseDone();
    lcd_done = 1'b1;
    idle(1);
    lcd_done = 1'b0;
  endtask

  task automatic doReset();
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_cmd_valid",  32'(cmd_valid),  0);
    checkOutput("rst_cmd",        32'(cmd),        0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 0);
    checkOutput("rst_issued_cnt", 32'(issued_cnt), 0);
    checkOutput("rst_sched_done", 32'(sched_done), 0);
    checkOutput("rst_host_ready", 32'(host_ready), 0);
    host_valid = 1'b0;
    lcd_done   = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    host_valid = 1'b0;
    host_cmd   = 3'd0;
    lcd_done   = 1'b0;
    fork
      forever begin
        @(negedge clk);
        checkOutput("host_ready", 32'(host_ready), int'(m_booted && !m_wseen && (m_q.size() < DEPTH)));
        checkOutput("cmd_valid",  32'(cmd_valid),  int'(m_cv));
        checkOutput("cmd",        32'(cmd),        m_cmd);
        checkOutput("fifo_count", 32'(fifo_count), m_q.size());
        checkOutput("issued_cnt", 32'(issued_cnt), m_cnt);
        checkOutput("sched_done", 32'(sched_done), int'(m_done));
      end
    join_none

    // Boot gating: busy held high after reset keeps the host out.
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    host_valid = 1'b1;
    host_cmd   = 3'd3;
    idle(20);
    checkOutput("boot_no_issue", 32'(issued_cnt), 0);
    ctl_mode = 0;
    applyStimulus(3'd3, 10, 1'b1);
    idle(12);

    // Fill while busy, refuse on full, then drain against a pulsing controller.
    ctl_mode = 1;
    idle(2);
    applyStimulus(3'd1, 10, 1'b1);
    applyStimulus(3'd2, 10, 1'b1);
    applyStimulus(3'd3, 10, 1'b1);
    applyStimulus(3'd4, 10, 1'b1);
    checkOutput("full_count", 32'(fifo_count), 4);
    applyStimulus(3'd5, 4, 1'b0);
    ctl_mode = 3;
    idle(80);

    // Fast controller: timeout path back to back.
    ctl_mode = 0;
    idle(2);
    applyStimulus(3'd1, 10, 1'b1);
    applyStimulus(3'd2, 10, 1'b1);
    applyStimulus(3'd3, 10, 1'b1);
    idle(25);

    // Push and pop on the same edge.
    ctl_mode = 1;
    idle(2);
    applyStimulus(3'd6, 10, 1'b1);
    ctl_mode = 0;
    applyStimulus(3'd7, 10, 1'b1);
    idle(20);

    // WRITE termination with an early, ignored lcd_done.
    ctl_mode = 3;
    applyStimulus(3'd5, 10, 1'b1);
    pulseDone();
    applyStimulus(3'd0, 10, 1'b1);
    applyStimulus(3'd6, 8, 1'b0);
    idle(40);
    pulseDone();
    idle(10);
    checkOutput("sched_done_set", 32'(sched_done), 1);

    // Reset while waiting for busy release with three entries queued.
    ctl_mode = 0;
    doReset();
    idle(3);
    applyStimulus(3'd1, 10, 1'b1);
    idle(1);
    ctl_mode = 1;
    applyStimulus(3'd2, 10, 1'b1);
    applyStimulus(3'd3, 10, 1'b1);
    applyStimulus(3'd4, 10, 1'b1);
    checkOutput("pre_rst_count", 32'(fifo_count), 3);
    doReset();
    idle(1);
    checkOutput("post_rst_count", 32'(fifo_count), 0);
    checkOutput("post_rst_ready", 32'(host_ready), 0);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      ctl_mode = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 2 : 3);
      doReset();
      for (int c = 0; c < 150; c++) begin
        host_valid = ($urandom_range(0, 2) != 0);
        host_cmd   = ($urandom_range(0, 11) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        lcd_done   = ($urandom_range(0, 15) == 0);
        idle(1);
      end
      host_valid = 1'b0;
      lcd_done   = 1'b0;
      idle(20);
    end

    // Issue counter wrap past 255.
    ctl_mode = 0;
    doReset();
    idle(2);
    for (int k = 0; k < 260; k++) begin
      applyStimulus(3'($urandom_range(1, 7)), 20, 1'b1);
    end
    idle(40);
    checkOutput("wrap_cnt", 32'(issued_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
